reg_status_table: RTL and testbench
===================================

# reg_status_table

Parametrised register-status (rename) table for the Tomasulo/ROB core. It records, per architectural register, whether a result is pending and which ROB entry will produce it. The table sits between issue and the reservation stations. Unlike the previous single-port, event-driven table, it is fully clocked and adds:
- commit-port clearing with tag matching
- a global flush
- a separate busy bit instead of an in-band invalid code
- a registered lookup handshake
- a busy-register counter

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired never-busy.
- ROB_DEPTH, 16, number of ROB entries; TAG_W = $clog2(ROB_DEPTH).
- NUM_COMMIT, 2, number of commit (clear) ports.
- RA_W = $clog2(NUM_REGS), CNT_W = $clog2(NUM_REGS+1), both derived.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- lookup_valid  in  1  request to read two source registers.
- src1, src2  in  RA_W  source register indices.
- lookup_done  out  1  one-cycle pulse; q outputs valid.
- q1_busy, q2_busy  out  1  source register is pending.
- q1_tag, q2_tag  out  TAG_W  producing ROB entry; forced to 0 when the matching busy bit is 0.
- rename_en  in  1  mark a destination as pending.
- rename_reg  in  RA_W  destination register.
- rename_tag  in  TAG_W  ROB entry allocated to it.
- commit_en  in  NUM_COMMIT  per-port commit strobe.
- commit_reg  in  NUM_COMMIT*RA_W  per-port register, packed; port k occupies bits [k*RA_W +: RA_W].
- commit_tag  in  NUM_COMMIT*TAG_W  per-port committing ROB tag, packed the same way.
- flush  in  1  clear all busy bits (mispredict/exception).
- probe_reg  in  RA_W  combinational debug/ROB probe index.
- probe_busy, probe_tag  out  1, TAG_W  current table state for probe_reg (pre-edge state, no forwarding).
- busy_count  out  CNT_W  number of busy registers.

## Operation
- Table state: busy[r] and tag[r] for each r in 0..NUM_REGS-1.

Commit:
- Port k clears busy[commit_reg_k] only if it is busy and tag[commit_reg_k] == commit_tag_k.
- A stale commit, where the register has since been renamed to a newer tag, is ignored.
- Commit to register 0 is ignored.

Rename:
- Sets busy[rename_reg]=1 and tag[rename_reg]=rename_tag.
- rename_reg==0 is ignored.

Same-register priority within one cycle: flush > rename > commit.
- Rename plus matching commit on the same register: the register ends busy with the new tag.
- Two commit ports naming the same register: clearing happens if either tag matches.

Flush:
- Next state is all busy=0. Tags are don't-care but are reset to 0.
- Same-cycle rename and commit are discarded.

Lookup:
- lookup_valid in cycle N samples src1/src2 against the state as it stands before edge N, with this cycle's valid commits forwarded.
- The cycle-N rename is NOT forwarded, because the renaming instruction reads its sources before allocating its destination.
- Same-cycle flush is forwarded: both q outputs report not-busy.
- src index 0 always returns busy=0, tag=0.
- No backpressure; back-to-back lookups are accepted every cycle.

busy_count:
- Registered.
- Equals the popcount of the busy bits after the edge.
- Never exceeds NUM_REGS-1.

## Timing
- Reset: all busy=0, all tag=0, lookup_done=0, q1/q2 busy=0 and tag=0, busy_count=0.
- rst dominates flush, rename, commit and lookup.
- Lookup latency: exactly 1 cycle. Request at edge N gives lookup_done=1 with q outputs valid after edge N, held until the next edge.
- q outputs retain their last value when lookup_done=0.
- Rename or commit becomes visible to a lookup issued in the following cycle. A commit is also visible to a lookup in the same cycle through forwarding.
- probe outputs are purely combinational from the table registers.
- rst asserted mid-lookup: lookup_done=0 in the next cycle, and the request is lost.

## Test plan
- Reset, then lookup src1=3, src2=0 -> next cycle lookup_done=1, q1_busy=0, q2_busy=0, busy_count=0.
- Rename r5 with tag 7; next cycle lookup src1=5 -> q1_busy=1, q1_tag=7; busy_count=1.
- r5 renamed with tag 7, then with tag 9; commit r5 tag 7 -> r5 stays busy, tag 9. Commit r5 tag 9 -> r5 clears, busy_count=0.
- Same cycle: lookup src1=5, commit r5 tag 9, rename r5 tag 2 -> q1_busy=0 (commit forwarded, rename not). Next lookup -> busy, tag 2.
- Rename r1..r31 with tags i%16 -> busy_count=31. Rename r0 -> no effect. Flush with a concurrent rename of r4 -> busy_count=0, r4 not busy.
- Two commit ports clear r3 (tag 1) and r8 (tag 4) in one cycle -> both free; busy_count decreases by 2.

Source files
------------

// File: rtl/reg_status_table.sv
// Register-status (rename) table: per architectural register, a busy bit and the ROB tag
// that will produce its value. Supports rename, tag-matched commit clearing, flush and a 1-cycle lookup.
module reg_status_table #(
    parameter int NUM_REGS   = 32,
    parameter int ROB_DEPTH  = 16,
    parameter int NUM_COMMIT = 2,
    parameter int TAG_W      = $clog2(ROB_DEPTH),
    parameter int RA_W       = $clog2(NUM_REGS),
    parameter int CNT_W      = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lookup_valid,
    input  logic [RA_W-1:0]            src1,
    input  logic [RA_W-1:0]            src2,
    output logic                       lookup_done,
    output logic                       q1_busy,
    output logic                       q2_busy,
    output logic [TAG_W-1:0]           q1_tag,
    output logic [TAG_W-1:0]           q2_tag,
    input  logic                       rename_en,
    input  logic [RA_W-1:0]            rename_reg,
    input  logic [TAG_W-1:0]           rename_tag,
    input  logic [NUM_COMMIT-1:0]      commit_en,
    input  logic [NUM_COMMIT*RA_W-1:0] commit_reg,
    input  logic [NUM_COMMIT*TAG_W-1:0] commit_tag,
    input  logic                       flush,
    input  logic [RA_W-1:0]            probe_reg,
    output logic                       probe_busy,
    output logic [TAG_W-1:0]           probe_tag,
    output logic [CNT_W-1:0]           busy_count
);

    // Lookup handshake: lookup_valid is accepted every cycle (no ready); lookup_done pulses
    // exactly one cycle later with q outputs valid, and q outputs hold otherwise.

    logic [NUM_REGS-1:0] busy_q;
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d;
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [NUM_REGS-1:0] clr;
    logic [CNT_W-1:0]    cnt_d;
    logic                q1_busy_d;
    logic                q2_busy_d;
    logic [TAG_W-1:0]    q1_tag_d;
    logic [TAG_W-1:0]    q2_tag_d;

    // A commit clears only when its tag still owns the register; stale commits fall through.
    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (commit_en[k] &&
                    commit_reg[k*RA_W +: RA_W] == RA_W'(r) &&
                    busy_q[r] &&
                    tag_q[r] == commit_tag[k*TAG_W +: TAG_W]) begin
                    clr[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            tag_d[r] = tag_q[r];
        end
        if (flush) begin
            busy_d = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_d[r] = '0;
            end
        end else begin
            busy_d = busy_q & ~clr;
            if (rename_en && rename_reg != '0) begin
                busy_d[rename_reg] = 1'b1;
                tag_d[rename_reg]  = rename_tag;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    // Sources see this cycle's commits and flush, but not this cycle's rename.
    always_comb begin
        q1_busy_d = !flush && (src1 != '0) && busy_q[src1] && !clr[src1];
        q2_busy_d = !flush && (src2 != '0) && busy_q[src2] && !clr[src2];
        q1_tag_d  = q1_busy_d ? tag_q[src1] : '0;
        q2_tag_d  = q2_busy_d ? tag_q[src2] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
            busy_count  <= '0;
            lookup_done <= 1'b0;
            q1_busy     <= 1'b0;
            q2_busy     <= 1'b0;
            q1_tag      <= '0;
            q2_tag      <= '0;
        end else begin
            busy_q      <= busy_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= tag_d[r];
            end
            busy_count  <= cnt_d;
            lookup_done <= lookup_valid;
            if (lookup_valid) begin
                q1_busy <= q1_busy_d;
                q2_busy <= q2_busy_d;
                q1_tag  <= q1_tag_d;
                q2_tag  <= q2_tag_d;
            end
        end
    end

    assign probe_busy = busy_q[probe_reg];
    assign probe_tag  = tag_q[probe_reg];

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: reference model of the table, lookup scoreboard,
// directed scenarios followed by a random mix.
module tb_reg_status_table;

    localparam int RA_W  = 5;
    localparam int TAG_W = 4;
    localparam int CNT_W = 6;
    localparam int QW    = 2 * (1 + TAG_W);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                lookup_valid = 1'b0;
    logic [RA_W-1:0]     src1 = '0, src2 = '0;
    logic                lookup_done, q1_busy, q2_busy;
    logic [TAG_W-1:0]    q1_tag, q2_tag;
    logic                rename_en = 1'b0;
    logic [RA_W-1:0]     rename_reg = '0;
    logic [TAG_W-1:0]    rename_tag = '0;
    logic [1:0]          commit_en = '0;
    logic [2*RA_W-1:0]   commit_reg = '0;
    logic [2*TAG_W-1:0]  commit_tag = '0;
    logic                flush = 1'b0;
    logic [RA_W-1:0]     probe_reg = '0;
    logic                probe_busy;
    logic [TAG_W-1:0]    probe_tag;
    logic [CNT_W-1:0]    busy_count;

    int total = 0;
    int bad   = 0;

    logic             m_busy [32];
    logic [TAG_W-1:0] m_tag  [32];
    logic [QW-1:0]    exp_q[$];

    reg_status_table dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .src1(src1), .src2(src2),
        .lookup_done(lookup_done), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .rename_en(rename_en), .rename_reg(rename_reg), .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_reg(commit_reg), .commit_tag(commit_tag),
        .flush(flush), .probe_reg(probe_reg), .probe_busy(probe_busy),
        .probe_tag(probe_tag), .busy_count(busy_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // scoreboard: each lookup_done pops one expected {q1_busy,q1_tag,q2_busy,q2_tag}
    always @(negedge clk) begin
        if (lookup_done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL lookup_unexpected: got lookup_done=1, want 0 (no request pending)");
            end else begin
                logic [QW-1:0] e;
                e = exp_q.pop_front();
                if ({q1_busy, q1_tag, q2_busy, q2_tag} !== e) begin
                    bad++;
                    $display("FAIL lookup_q: got %b/%0d %b/%0d, want %b/%0d %b/%0d",
                             q1_busy, q1_tag, q2_busy, q2_tag,
                             e[QW-1], e[QW-2 -: TAG_W], e[TAG_W], e[TAG_W-1:0]);
                end
            end
        end
    end

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
        exp_q.delete();
    endtask

    // driver: one cycle of stimulus, expected lookup pushed, model advanced
    task automatic drive(input logic lv, input logic [RA_W-1:0] s1, input logic [RA_W-1:0] s2,
                         input logic ren, input logic [RA_W-1:0] rr, input logic [TAG_W-1:0] rt,
                         input logic [1:0] ce,
                         input logic [RA_W-1:0] cr0, input logic [TAG_W-1:0] ct0,
                         input logic [RA_W-1:0] cr1, input logic [TAG_W-1:0] ct1,
                         input logic fl);
        logic             clr [32];
        logic             b1, b2;
        logic [RA_W-1:0]  cr [2];
        logic [TAG_W-1:0] ct [2];
        cr[0] = cr0; cr[1] = cr1; ct[0] = ct0; ct[1] = ct1;
        lookup_valid = lv; src1 = s1; src2 = s2;
        rename_en = ren; rename_reg = rr; rename_tag = rt;
        commit_en = ce; commit_reg = {cr1, cr0}; commit_tag = {ct1, ct0};
        flush = fl;
        for (int r = 0; r < 32; r++) clr[r] = 1'b0;
        for (int k = 0; k < 2; k++)
            if (ce[k] && cr[k] != 0 && m_busy[cr[k]] && m_tag[cr[k]] == ct[k]) clr[cr[k]] = 1'b1;
        if (lv) begin
            b1 = !fl && s1 != 0 && m_busy[s1] && !clr[s1];
            b2 = !fl && s2 != 0 && m_busy[s2] && !clr[s2];
            exp_q.push_back({b1, b1 ? m_tag[s1] : 4'd0, b2, b2 ? m_tag[s2] : 4'd0});
        end
        if (fl) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = 1'b0; m_tag[r] = '0; end
        end else begin
            for (int r = 0; r < 32; r++) if (clr[r]) m_busy[r] = 1'b0;
            if (ren && rr != 0) begin m_busy[rr] = 1'b1; m_tag[rr] = rt; end
        end
        @(posedge clk);
        #1;
        lookup_valid = 1'b0; rename_en = 1'b0; commit_en = '0; flush = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [RA_W-1:0] s1, input logic [RA_W-1:0] s2);
        drive(1, s1, s2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic rename(input logic [RA_W-1:0] r, input logic [TAG_W-1:0] t);
        drive(0, 0, 0, 1, r, t, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; lookup_valid = 1'b1; src1 = 5'd3;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; lookup_valid = 1'b0;
        total++;
        if ({lookup_done, q1_busy, q1_tag, q2_busy, q2_tag, busy_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got done=%b q1=%b/%0d q2=%b/%0d cnt=%0d, want all 0",
                     lookup_done, q1_busy, q1_tag, q2_busy, q2_tag, busy_count);
        end
        lookup(5'd3, 5'd0);
        idle();
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d, want 0", busy_count);
        end
    endtask

    task automatic test_rename();
        rename(5'd5, 4'd7);
        lookup(5'd5, 5'd6);
        total++;
        if (busy_count !== 6'd1) begin
            bad++;
            $display("FAIL rename_count: got %0d, want 1", busy_count);
        end
        probe_reg = 5'd5; #1;
        total++;
        if ({probe_busy, probe_tag} !== {1'b1, 4'd7}) begin
            bad++;
            $display("FAIL rename_probe: got %b/%0d, want 1/7", probe_busy, probe_tag);
        end
    endtask

    task automatic test_stale_commit();
        rename(5'd5, 4'd9);
        drive(1, 5, 0, 0, 0, 0, 2'b01, 5, 7, 0, 0, 0);
        lookup(5'd5, 5'd0);
        drive(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 5, 9, 0);
        total++;
        if (busy_count !== 6'd0) begin
            bad++;
            $display("FAIL stale_commit_count: got %0d, want 0", busy_count);
        end
    endtask

    task automatic test_forward();
        rename(5'd5, 4'd9);
        drive(1, 5, 5, 1, 5, 2, 2'b01, 5, 9, 0, 0, 0);
        lookup(5'd5, 5'd0);
        probe_reg = 5'd5; #1;
        total++;
        if ({probe_busy, probe_tag, busy_count} !== {1'b1, 4'd2, 6'd1}) begin
            bad++;
            $display("FAIL forward_state: got %b/%0d cnt=%0d, want 1/2 cnt=1",
                     probe_busy, probe_tag, busy_count);
        end
    endtask

    task automatic test_fill_flush();
        for (int i = 1; i < 32; i++) rename(RA_W'(i), TAG_W'(i % 16));
        total++;
        if (busy_count !== 6'd31) begin
            bad++;
            $display("FAIL fill_count: got %0d, want 31", busy_count);
        end
        rename(5'd0, 4'd3);
        probe_reg = 5'd0; #1;
        total++;
        if ({probe_busy, busy_count} !== {1'b0, 6'd31}) begin
            bad++;
            $display("FAIL r0_rename: got busy=%b cnt=%0d, want busy=0 cnt=31", probe_busy, busy_count);
        end
        lookup(5'd17, 5'd0);
        drive(1, 4, 7, 1, 4, 5, 2'b01, 9, 9, 0, 0, 1);
        probe_reg = 5'd4; #1;
        total++;
        if ({probe_busy, busy_count} !== {1'b0, 6'd0}) begin
            bad++;
            $display("FAIL flush_state: got r4 busy=%b cnt=%0d, want 0 cnt=0", probe_busy, busy_count);
        end
    endtask

    task automatic test_dual_commit();
        rename(5'd3, 4'd1);
        rename(5'd8, 4'd4);
        rename(5'd6, 4'd3);
        total++;
        if (busy_count !== 6'd3) begin
            bad++;
            $display("FAIL dual_pre_count: got %0d, want 3", busy_count);
        end
        drive(1, 3, 8, 0, 0, 0, 2'b11, 3, 1, 8, 4, 0);
        total++;
        if (busy_count !== 6'd1) begin
            bad++;
            $display("FAIL dual_commit_count: got %0d, want 1", busy_count);
        end
        drive(1, 6, 0, 0, 0, 0, 2'b11, 6, 5, 6, 3, 0);
        probe_reg = 5'd6; #1;
        total++;
        if ({probe_busy, busy_count} !== {1'b0, 6'd0}) begin
            bad++;
            $display("FAIL same_reg_commit: got busy=%b cnt=%0d, want 0 cnt=0", probe_busy, busy_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            logic [RA_W-1:0]  cr0, cr1;
            logic [TAG_W-1:0] ct0, ct1;
            cr0 = RA_W'($urandom_range(0, 31));
            cr1 = RA_W'($urandom_range(0, 31));
            ct0 = ($urandom_range(0, 2) != 0) ? m_tag[cr0] : TAG_W'($urandom_range(0, 15));
            ct1 = ($urandom_range(0, 2) != 0) ? m_tag[cr1] : TAG_W'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), RA_W'($urandom_range(0, 31)), RA_W'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), RA_W'($urandom_range(0, 31)), TAG_W'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), cr0, ct0, cr1, ct1, 1'($urandom_range(0, 40) == 0));
            probe_reg = RA_W'($urandom_range(0, 31)); #1;
            total++;
            if ({probe_busy, probe_tag} !== {m_busy[probe_reg], m_tag[probe_reg]} ||
                busy_count !== CNT_W'(model_count())) begin
                bad++;
                $display("FAIL random_state: r%0d got %b/%0d cnt=%0d, want %b/%0d cnt=%0d",
                         probe_reg, probe_busy, probe_tag, busy_count,
                         m_busy[probe_reg], m_tag[probe_reg], model_count());
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rename(5'd9, 4'd6);
        lookup_valid = 1'b1; src1 = 5'd9; rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; lookup_valid = 1'b0;
        total++;
        if ({lookup_done, q1_busy, busy_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got done=%b q1=%b cnt=%0d, want 0 0 0", lookup_done, q1_busy, busy_count);
        end
        lookup(5'd9, 5'd0);
        idle();
    endtask

    initial begin
        test_reset();
        test_rename();
        test_stale_commit();
        test_forward();
        test_fill_flush();
        test_dual_commit();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL lookup_missing: got %0d unanswered, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
